// File: rtl/grid_link_pkg.sv
// rtl/grid_link_pkg.sv - shared types and constants for the Game-of-Life engine host driver
package grid_link_pkg;

    localparam int CELLS_DEF = 25;
    localparam int GENW_DEF  = 8;

    localparam logic [1:0] ENG_INPUT  = 2'b00;
    localparam logic [1:0] ENG_UPDATE = 2'b01;
    localparam logic [1:0] ENG_OUTPUT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_SHIFT,
        ST_START,
        ST_RUN,
        ST_HALT
    } host_state_t;

endpackage

// File: rtl/frame_capture.sv
// rtl/frame_capture.sv - deserializes engine output samples and flags complete or short generations
module frame_capture
    import grid_link_pkg::*;
#(
    parameter int CELLS = CELLS_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [1:0]       eng_state,
    input  logic             eng_dout,
    output logic [CELLS-1:0] samples,
    output logic             done,
    output logic             short_frame
);

    localparam int CW = $clog2(CELLS + 1) + 1;

    logic [CW-1:0] count;
    logic [1:0]    prev_state;
    logic          edge_seen;

    // A generation ends when the engine leaves OUTPUT for UPDATE.
    assign edge_seen   = enable && (prev_state == ENG_OUTPUT) && (eng_state == ENG_UPDATE);
    assign done        = edge_seen && (count >= CW'(CELLS));
    assign short_frame = edge_seen && (count <  CW'(CELLS));

    // Newest sample enters at the MSB so bit 0 holds the earliest of the last CELLS samples.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            samples    <= '0;
            count      <= '0;
            prev_state <= ENG_INPUT;
        end else begin
            prev_state <= eng_state;
            if (!enable || edge_seen) begin
                count <= '0;
            end else if (eng_state == ENG_OUTPUT) begin
                samples <= {eng_dout, samples[CELLS-1:1]};
                if (count != '1) begin
                    count <= count + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/grid_link_host.sv
// rtl/grid_link_host.sv - loads a pattern into the serial Life engine and collects its generations
module grid_link_host
    import grid_link_pkg::*;
#(
    parameter int CELLS = CELLS_DEF,
    parameter int GENW  = GENW_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic [CELLS-1:0] pat_data,
    input  logic [GENW-1:0]  pat_gens,
    input  logic             abort,
    output logic             eng_din,
    output logic             eng_start,
    output logic             eng_reset,
    input  logic             eng_dout,
    input  logic [1:0]       eng_state,
    output logic             frm_valid,
    input  logic             frm_ready,
    output logic [CELLS-1:0] frm_data,
    output logic [GENW-1:0]  frm_idx,
    output logic             busy,
    output logic [1:0]       err
);

    // Shared counter covers both the bit shift and the 16-cycle start timeout.
    localparam int SW = ($clog2(CELLS + 1) > 4) ? $clog2(CELLS + 1) : 4;

    host_state_t      state;
    logic [CELLS-1:0] pat_q;
    logic [GENW-1:0]  gens_q;
    logic [SW-1:0]    cnt;
    logic [GENW-1:0]  idx_next;
    logic             cap_en;
    logic             cap_done;
    logic             cap_short;
    logic [CELLS-1:0] cap_samples;

    assign cap_en   = (state == ST_START) || (state == ST_RUN);
    assign idx_next = frm_idx + GENW'(1);

    frame_capture #(.CELLS(CELLS)) u_capture (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (cap_en),
        .eng_state   (eng_state),
        .eng_dout    (eng_dout),
        .samples     (cap_samples),
        .done        (cap_done),
        .short_frame (cap_short)
    );

    // Host FSM with registered engine controls and frame handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            pat_q     <= '0;
            gens_q    <= '0;
            cnt       <= '0;
            pat_ready <= 1'b1;
            busy      <= 1'b0;
            eng_din   <= 1'b0;
            eng_start <= 1'b0;
            eng_reset <= 1'b0;
            frm_valid <= 1'b0;
            frm_data  <= '0;
            frm_idx   <= '0;
            err       <= '0;
        end else begin
            eng_din   <= 1'b0;
            eng_start <= 1'b0;
            eng_reset <= 1'b0;
            if (frm_valid && frm_ready) begin
                frm_valid <= 1'b0;
            end

            if (abort && (state != ST_IDLE)) begin
                state     <= ST_HALT;
                eng_reset <= 1'b1;
                frm_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (pat_valid) begin
                            pat_q     <= pat_data;
                            gens_q    <= pat_gens;
                            err       <= '0;
                            frm_idx   <= '0;
                            pat_ready <= 1'b0;
                            busy      <= 1'b1;
                            eng_reset <= 1'b1;
                            state     <= ST_RST;
                        end
                    end
                    ST_RST: begin
                        eng_din <= pat_q[CELLS-1];
                        pat_q   <= {pat_q[CELLS-2:0], 1'b0};
                        cnt     <= SW'(1);
                        state   <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (cnt == SW'(CELLS)) begin
                            eng_start <= 1'b1;
                            cnt       <= '0;
                            state     <= ST_START;
                        end else begin
                            eng_din <= pat_q[CELLS-1];
                            pat_q   <= {pat_q[CELLS-2:0], 1'b0};
                            cnt     <= cnt + SW'(1);
                        end
                    end
                    ST_START: begin
                        if (eng_state != ENG_INPUT) begin
                            state <= ST_RUN;
                        end else if (cnt == SW'(15)) begin
                            err[0]    <= 1'b1;
                            eng_reset <= 1'b1;
                            state     <= ST_HALT;
                        end else begin
                            eng_start <= 1'b1;
                            cnt       <= cnt + SW'(1);
                        end
                    end
                    ST_RUN: begin
                        if (cap_short) begin
                            err[0] <= 1'b1;
                        end
                        if (cap_done) begin
                            // The engine cannot stall, so an unconsumed frame forces a drop.
                            if (frm_valid && !frm_ready) begin
                                err[1] <= 1'b1;
                            end else begin
                                frm_data  <= cap_samples;
                                frm_valid <= 1'b1;
                            end
                            frm_idx <= idx_next;
                            if ((gens_q != '0) && (idx_next == gens_q)) begin
                                eng_reset <= 1'b1;
                                state     <= ST_HALT;
                            end
                        end
                    end
                    ST_HALT: begin
                        pat_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                    default: begin
                        pat_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_grid_link_host.sv
// tb/tb_grid_link_host.sv - directed self-checking bench for grid_link_host
module tb_grid_link_host;

    localparam int CELLS = 25;
    localparam int GENW  = 8;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             pat_valid = 1'b0;
    logic             pat_ready;
    logic [CELLS-1:0] pat_data = '0;
    logic [GENW-1:0]  pat_gens = '0;
    logic             abort = 1'b0;
    logic             eng_din;
    logic             eng_start;
    logic             eng_reset;
    logic             eng_dout = 1'b0;
    logic [1:0]       eng_state = 2'b00;
    logic             frm_valid;
    logic             frm_ready = 1'b1;
    logic [CELLS-1:0] frm_data;
    logic [GENW-1:0]  frm_idx;
    logic             busy;
    logic [1:0]       err;

    int passed = 0;
    int total  = 0;
    logic [CELLS-1:0] rx;

    grid_link_host #(.CELLS(CELLS), .GENW(GENW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .pat_data  (pat_data),
        .pat_gens  (pat_gens),
        .abort     (abort),
        .eng_din   (eng_din),
        .eng_start (eng_start),
        .eng_reset (eng_reset),
        .eng_dout  (eng_dout),
        .eng_state (eng_state),
        .frm_valid (frm_valid),
        .frm_ready (frm_ready),
        .frm_data  (frm_data),
        .frm_idx   (frm_idx),
        .busy      (busy),
        .err       (err)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [CELLS-1:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            eng_state = 2'b10;
            eng_dout  = bits[i];
            tick;
        end
        eng_state = 2'b01;
        eng_dout  = 1'b0;
        tick;
    endtask

    task automatic load(input logic [CELLS-1:0] pat, input logic [GENW-1:0] gens);
        eng_state = 2'b00;
        pat_data  = pat;
        pat_gens  = gens;
        pat_valid = 1'b1;
        tick;
        pat_valid = 1'b0;
        repeat (26) tick;
    endtask

    initial begin
        // reset values
        tick;
        tick;
        chk("rst_pat_ready", 32'(pat_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_eng", 32'({eng_din, eng_start, eng_reset}), 32'd0);
        chk("rst_frm", 32'({frm_valid, frm_idx, err}), 32'd0);
        chk("rst_frm_data", 32'(frm_data), 32'd0);
        reset_n = 1'b1;
        tick;

        // blinker, two generations, consumer always ready
        pat_data  = 25'h0000380;
        pat_gens  = 8'd2;
        pat_valid = 1'b1;
        tick;
        pat_valid = 1'b0;
        chk("t1_eng_reset", 32'(eng_reset), 32'd1);
        chk("t1_busy", 32'({busy, pat_ready}), 32'b10);
        tick;
        chk("t1_eng_reset_low", 32'(eng_reset), 32'd0);
        for (int j = 0; j < CELLS; j++) begin
            rx[CELLS-1-j] = eng_din;
            chk("t1_no_start", 32'(eng_start), 32'd0);
            tick;
        end
        chk("t1_din_bits", 32'(rx), 32'h0000380);
        chk("t1_start_hi", 32'(eng_start), 32'd1);
        eng_state = 2'b01;
        tick;
        chk("t1_start_lo", 32'(eng_start), 32'd0);
        send_frame(25'h0002108, 25);
        chk("t1_f1_valid", 32'(frm_valid), 32'd1);
        chk("t1_f1_data", 32'(frm_data), 32'h0002108);
        chk("t1_f1_idx", 32'(frm_idx), 32'd1);
        send_frame(25'h0000380, 25);
        chk("t1_f2_valid", 32'(frm_valid), 32'd1);
        chk("t1_f2_data", 32'(frm_data), 32'h0000380);
        chk("t1_f2_idx", 32'(frm_idx), 32'd2);
        chk("t1_halt_reset", 32'(eng_reset), 32'd1);
        tick;
        chk("t1_idle", 32'({busy, pat_ready, eng_reset}), 32'b010);
        chk("t1_err", 32'(err), 32'd0);

        // short generation of 20 samples
        load(25'h0000380, 8'd1);
        chk("t2_start_hi", 32'(eng_start), 32'd1);
        eng_state = 2'b01;
        tick;
        send_frame(25'h00FFFFF, 20);
        chk("t2_err", 32'(err), 32'b01);
        chk("t2_no_valid", 32'(frm_valid), 32'd0);
        chk("t2_idx", 32'(frm_idx), 32'd0);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        tick;
        chk("t2_idle", 32'(busy), 32'd0);

        // backpressure: first frame held, later frames dropped
        frm_ready = 1'b0;
        load(25'h0000380, 8'd3);
        chk("t3_err_cleared", 32'(err), 32'd0);
        eng_state = 2'b01;
        tick;
        send_frame(25'h0002108, 25);
        chk("t3_f1", 32'({frm_valid, frm_idx}), 32'h101);
        send_frame(25'h0000380, 25);
        chk("t3_f2_data", 32'(frm_data), 32'h0002108);
        chk("t3_f2_err", 32'(err), 32'b10);
        send_frame(25'h1555555, 25);
        chk("t3_f3_idx", 32'(frm_idx), 32'd3);
        chk("t3_f3_data", 32'(frm_data), 32'h0002108);
        chk("t3_halt", 32'({eng_reset, err}), 32'b110);
        tick;
        chk("t3_idle_pending", 32'({busy, frm_valid}), 32'b01);

        // abort during shift at bit 10 drops the pending frame
        eng_state = 2'b00;
        pat_data  = 25'h1F0F0F0;
        pat_gens  = 8'd0;
        pat_valid = 1'b1;
        tick;
        pat_valid = 1'b0;
        tick;
        repeat (10) tick;
        chk("t4_still_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("t4_halt_reset", 32'({eng_reset, eng_din}), 32'b10);
        tick;
        chk("t4_idle", 32'({pat_ready, busy, frm_valid, eng_reset}), 32'b1000);
        frm_ready = 1'b1;

        // engine never leaves INPUT after start
        load(25'h0000380, 8'd1);
        repeat (15) tick;
        chk("t5_waiting", 32'({eng_start, err}), 32'b100);
        tick;
        chk("t5_timeout", 32'({eng_reset, eng_start, err}), 32'b1001);
        tick;
        chk("t5_idle", 32'({busy, pat_ready}), 32'b01);

        // asynchronous reset during RUN
        load(25'h0000380, 8'd0);
        eng_state = 2'b01;
        tick;
        send_frame(25'h0002108, 25);
        chk("t6_pre", 32'({frm_valid, frm_idx}), 32'h101);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_ctrl", 32'({pat_ready, busy, eng_din, eng_start, eng_reset}), 32'b10000);
        chk("t6_rst_frm", 32'({frm_valid, frm_idx, err}), 32'd0);
        chk("t6_rst_data", 32'(frm_data), 32'd0);
        eng_state = 2'b00;
        tick;
        reset_n = 1'b1;
        tick;
        pat_data  = 25'h0000380;
        pat_gens  = 8'd1;
        pat_valid = 1'b1;
        tick;
        pat_valid = 1'b0;
        chk("t6_accept", 32'({busy, pat_ready, eng_reset}), 32'b101);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        tick;
        chk("t6_done", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/grid_link_host.md
# grid_link_host

Host-side driver for the serial Game-of-Life engine. It accepts a full grid pattern over a valid/ready port, resets the engine, shifts the pattern into the engine one bit per clock, and pulses start. It then deserializes every generation the engine streams out into a parallel frame, and halts the engine after a requested number of generations. It sits between a host or register interface and the engine, sharing the engine's clock.

## Interface
Parameters:
- CELLS, 25, grid cells per frame (SIDE×SIDE)
- GENW, 8, width of generation count and frame index

Ports:
- clock  in  1  single clock, shared with the engine
- reset_n  in  1  asynchronous, active-low reset
- pat_valid  in  1  pattern offered
- pat_ready  out  1  high only in IDLE
- pat_data  in  CELLS  initial grid; bit k = cell k
- pat_gens  in  GENW  frames to capture; 0 = run until abort
- abort  in  1  stop engine and return to IDLE
- eng_din  out  1  engine serial pattern input
- eng_start  out  1  engine start request
- eng_reset  out  1  engine synchronous reset, active-high
- eng_dout  in  1  engine serial cell output
- eng_state  in  2  engine phase: 00 INPUT, 01 UPDATE, 10 OUTPUT
- frm_valid  out  1  frame available
- frm_ready  in  1  frame consumed
- frm_data  out  CELLS  captured generation
- frm_idx  out  GENW  generation number of frm_data, first frame = 1
- busy  out  1  high in any state except IDLE
- err  out  2  sticky flags: [0] short frame, [1] overrun; cleared on pattern accept

## Operation
- States: IDLE, RST, SHIFT, START, RUN, HALT.
- IDLE: pat_ready=1. On pat_valid: latch pat_data and pat_gens, clear err and frm_idx, go to RST.
- RST: eng_reset=1 for one cycle, then go to SHIFT.
- SHIFT: CELLS cycles. eng_din = latched bit CELLS-1-j on cycle j, so the MSB is sent first. After the last bit, go to START.
- START: eng_start=1, eng_din=0. Hold until eng_state≠00, then go to RUN. If 16 cycles pass without that change, set err[0] and go to HALT.
- RUN:
  - While eng_state=10, shift eng_dout into the capture register and increment a saturating sample count.
  - On a 10→01 transition:
    - Count ≥ CELLS: publish the last CELLS samples (frm_data[0] = earliest of them) and increment frm_idx.
    - Count < CELLS: set err[0] and publish nothing.
    - In both cases, clear the count.
  - When frm_idx reaches a nonzero pat_gens, go to HALT after the publish.
- Backpressure: the engine cannot stall. If a frame completes while frm_valid=1 and frm_ready=0, drop the new frame, keep the old one, set err[1], and still increment frm_idx.
- HALT: eng_reset=1 for one cycle, then go to IDLE. A pending frame is retained.
- abort, in any non-IDLE state: next state is HALT and frm_valid is cleared. abort in IDLE is ignored.

## Timing
- Reset values: state IDLE, pat_ready=1, eng_din=0, eng_start=0, eng_reset=0, frm_valid=0, frm_data=0, frm_idx=0, busy=0, err=0.
- All outputs are registered. eng_reset, eng_din and eng_start change on the clock edge after the state decision.
- Pattern accepted at edge T:
  - eng_reset high during T+1
  - bits sent during T+2 … T+CELLS+1
  - eng_start high from T+CELLS+2
- Frame publish: frm_valid rises one cycle after the cycle in which eng_state=01 is first sampled following 10.
- frm_valid&frm_ready clears frm_valid at the next edge. A same-cycle new publish wins: frm_valid stays 1 with the new data, and no overrun is flagged.
- reset_n low mid-run: everything returns to reset values immediately. eng_reset is not asserted, so the engine must share the host reset.

## Structure
- Package grid_link_pkg holds:
  - host state enum
  - engine phase constants ENG_INPUT=2'b00, ENG_UPDATE=2'b01, ENG_OUTPUT=2'b10
  - default CELLS and GENW
- Sub-module frame_capture holds:
  - serial-in shift register, CELLS bits
  - saturating sample counter, $clog2(CELLS+1)+1 bits
  - a done/short output pulse on the 10→01 edge
- The top holds the FSM, the pattern shifter, and the frame output handshake.

## Test plan
- Pattern 25'h0000380 (blinker), gens=2, frm_ready=1: eng_din MSB-first over 25 cycles, one start pulse; frames idx 1 and 2 match the reference model, then HALT and eng_reset pulse, busy=0.
- Engine model emits only 20 OUTPUT samples: err=2'b01, no frm_valid, frm_idx unchanged.
- frm_ready=0, gens=3: frame 1 held, frames 2–3 dropped, err[1]=1, frm_idx=3 at HALT.
- abort asserted mid-SHIFT at bit 10: eng_reset pulse next cycle, IDLE, pat_ready=1, frm_valid=0.
- eng_state stuck at 00 after start: after 16 cycles err[0]=1, HALT, then IDLE.
- reset_n asserted during RUN: all outputs equal reset values in the same cycle; a new pattern is accepted after release.
